// File: rtl/ntt_gs_sched_if.sv
// Issue/write-back bus between the GS NTT scheduler and the coefficient RAM, twiddle ROM and PE.
// The stall input exists only when NTT_SCHED_STALL_EN is defined.
interface ntt_gs_sched_if #(
  parameter int unsigned LOG_N = 4
);
  localparam int unsigned SW = $clog2(LOG_N + 1);

  logic             start;
`ifdef NTT_SCHED_STALL_EN
  logic             stall;
`endif
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [LOG_N-1:0] rd_addr_top;
  logic [LOG_N-1:0] rd_addr_bot;
  logic [LOG_N-1:0] tw_addr;
  logic             pe_start;
  logic             wr_en;
  logic [LOG_N-1:0] wr_addr_top;
  logic [LOG_N-1:0] wr_addr_bot;
  logic [SW-1:0]    stage_o;

  modport master (
    output busy, done, rd_en, rd_addr_top, rd_addr_bot, tw_addr,
           pe_start, wr_en, wr_addr_top, wr_addr_bot, stage_o,
    input  start
`ifdef NTT_SCHED_STALL_EN
    , input stall
`endif
  );

  modport slave (
    input  busy, done, rd_en, rd_addr_top, rd_addr_bot, tw_addr,
           pe_start, wr_en, wr_addr_top, wr_addr_bot, stage_o,
    output start
`ifdef NTT_SCHED_STALL_EN
    , output stall
`endif
  );
endinterface

// File: rtl/ntt_gs_sched.sv
// Gentleman-Sande inverse NTT address sequencer: one butterfly issue per cycle, delayed write-back, inter-stage drain.
// Optional issue stall enabled by defining NTT_SCHED_STALL_EN.
module ntt_gs_sched #(
  parameter int unsigned LOG_N  = 4,
  parameter int unsigned PE_LAT = 4
) (
  input logic             clk,
  input logic             reset,
  ntt_gs_sched_if.master  bus
);
  localparam int unsigned AW     = LOG_N;
  localparam int unsigned SW     = $clog2(LOG_N + 1);
  localparam int unsigned N_HALF = 1 << (LOG_N - 1);
  localparam int unsigned D      = 1 + PE_LAT;
  localparam int unsigned DW     = $clog2(D + 1);

  localparam logic [AW-1:0] K_LAST    = AW'(N_HALF - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(LOG_N - 1);
  localparam logic [DW-1:0] DRAIN_LEN = DW'(D);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [AW-1:0] top;
    logic [AW-1:0] bot;
    logic [AW-1:0] tw;
  } addr_t;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] top;
    logic [AW-1:0] bot;
  } wb_t;

  state_t        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [AW-1:0] k_q, k_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          rd_q;
  addr_t         addr_q;
  logic          busy_q;
  logic          done_q;
  wb_t           pipe_q [D];
  logic          stall_c;
  logic          rd_en_c;
  logic          issue_c;

  // Butterfly k of stage s: pair spacing t = 2^s, group g shares one twiddle.
  function automatic addr_t calc_addr(input logic [SW-1:0] s, input logic [AW-1:0] k);
    logic [AW-1:0] t;
    logic [AW-1:0] g;
    logic [AW-1:0] j;
    addr_t         a;
    t     = AW'(1) << s;
    g     = k >> s;
    j     = k & (t - AW'(1));
    a.top = (g << (s + SW'(1))) | j;
    a.bot = a.top + t;
    a.tw  = AW'(N_HALF >> s) + g;
    return a;
  endfunction

`ifdef NTT_SCHED_STALL_EN
  assign stall_c = bus.stall;
`else
  assign stall_c = 1'b0;
`endif

  assign rd_en_c = rd_q & ~stall_c;
  assign issue_c = (state_q == RUN) && !stall_c;

  // Next-state logic: stage/butterfly counters and drain countdown.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        s_d = '0;
        k_d = '0;
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        if (issue_c) begin
          if (k_q == K_LAST) begin
            state_d = DRAIN;
            drain_d = DRAIN_LEN;
          end else begin
            k_d = k_q + AW'(1);
          end
        end
      end
      DRAIN: begin
        drain_d = drain_q - DW'(1);
        if (drain_q == DW'(1)) begin
          if (s_q < S_LAST) begin
            s_d     = s_q + SW'(1);
            k_d     = '0;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        s_d     = '0;
        k_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and issue-side output registers, loaded from next-state values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      drain_q <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      drain_q <= drain_d;
      rd_q    <= (state_d == RUN);
      addr_q  <= (state_d == RUN) ? calc_addr(s_d, k_d) : '0;
      busy_q  <= (state_d == RUN) || (state_d == DRAIN);
      done_q  <= (state_d == DONE);
    end
  end

  // Write-back alignment: issued tuple retires 1+PE_LAT cycles later.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(D); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{en: rd_en_c, top: addr_q.top, bot: addr_q.bot};
      for (int i = 1; i < int'(D); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rd_en       = rd_en_c;
  assign bus.rd_addr_top = addr_q.top;
  assign bus.rd_addr_bot = addr_q.bot;
  assign bus.tw_addr     = addr_q.tw;
  assign bus.stage_o     = s_q;
  assign bus.pe_start    = pipe_q[0].en;
  assign bus.wr_en       = pipe_q[D-1].en;
  assign bus.wr_addr_top = pipe_q[D-1].top;
  assign bus.wr_addr_bot = pipe_q[D-1].bot;

endmodule

// File: tb/tb_ntt_gs_sched.sv
// Scoreboard bench for ntt_gs_sched (LOG_N=3, PE_LAT=4); stall scenarios build with NTT_SCHED_STALL_EN.
module tb_ntt_gs_sched;
  localparam int LOG_N  = 3;
  localparam int PE_LAT = 4;
  localparam int N      = 1 << LOG_N;
  localparam int D      = 1 + PE_LAT;

  typedef struct {
    int cyc;
    int top;
    int bot;
    int tw;
    int stg;
  } exp_t;

  logic  clk = 1'b0;
  logic  reset;
  exp_t  rd_exp[$];
  exp_t  wr_exp[$];
  int    n_checks = 0;
  int    n_errors = 0;
  string phase = "init";

  always #5 clk = ~clk;

  ntt_gs_sched_if #(.LOG_N(LOG_N)) bus ();

  ntt_gs_sched #(.LOG_N(LOG_N), .PE_LAT(PE_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got %0d expected %0d", phase, tag, got, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({bus.busy, bus.done, bus.rd_en, bus.rd_addr_top, bus.rd_addr_bot, bus.tw_addr,
                bus.pe_start, bus.wr_en, bus.wr_addr_top, bus.wr_addr_bot, bus.stage_o});
  endfunction

  // Reference schedule: fills both queues and returns the expected done cycle.
  function automatic int build(input logic [127:0] stall_mask);
    int   c;
    int   t;
    exp_t e;
    c = 1;
    for (int s = 0; s < LOG_N; s++) begin
      t = 1 << s;
      for (int k = 0; k < N/2; k++) begin
        while (stall_mask[c] === 1'b1) c++;
        e.cyc = c;
        e.top = (k / t) * 2 * t + (k % t);
        e.bot = e.top + t;
        e.tw  = N / (2 * t) + k / t;
        e.stg = s;
        rd_exp.push_back(e);
        e.cyc = c + D;
        wr_exp.push_back(e);
        c++;
      end
      c += D;
    end
    return c;
  endfunction

  // Drives one transform starting at rel=0, comparing every cycle against the queues.
  task automatic run_transform(input logic [127:0] start_mask, input logic [127:0] stall_mask);
    int   done_cyc;
    logic prev_rd;
    exp_t e;
    done_cyc = build(stall_mask);
    prev_rd  = 1'b0;
    for (int rel = 0; rel <= done_cyc + 2; rel++) begin
      bus.start = (rel == 0) || (start_mask[rel] === 1'b1);
`ifdef NTT_SCHED_STALL_EN
      bus.stall = stall_mask[rel];
`endif
      @(negedge clk);
      check("pe_start", 32'(bus.pe_start), 32'(prev_rd));
      prev_rd = bus.rd_en;
      if (bus.rd_en === 1'b1) begin
        if (rd_exp.size() == 0) begin
          check("rd_extra", 32'(rel), 32'(0));
        end else begin
          e = rd_exp.pop_front();
          check("rd_cycle", 32'(rel), 32'(e.cyc));
          check("rd_top", 32'(bus.rd_addr_top), 32'(e.top));
          check("rd_bot", 32'(bus.rd_addr_bot), 32'(e.bot));
          check("tw", 32'(bus.tw_addr), 32'(e.tw));
          check("stage", 32'(bus.stage_o), 32'(e.stg));
        end
      end
      if (bus.wr_en === 1'b1) begin
        if (wr_exp.size() == 0) begin
          check("wr_extra", 32'(rel), 32'(0));
        end else begin
          e = wr_exp.pop_front();
          check("wr_cycle", 32'(rel), 32'(e.cyc));
          check("wr_top", 32'(bus.wr_addr_top), 32'(e.top));
          check("wr_bot", 32'(bus.wr_addr_bot), 32'(e.bot));
        end
      end
      check("busy", 32'(bus.busy), 32'(rel >= 1 && rel < done_cyc));
      check("done", 32'(bus.done), 32'(rel == done_cyc));
      if (rel == done_cyc) check("stage_at_done", 32'(bus.stage_o), 32'(LOG_N - 1));
      if (rel == done_cyc + 2) check("stage_idle", 32'(bus.stage_o), 32'(0));
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
`ifdef NTT_SCHED_STALL_EN
    bus.stall = 1'b0;
`endif
    check("rd_left", 32'(rd_exp.size()), 32'(0));
    check("wr_left", 32'(wr_exp.size()), 32'(0));
    rd_exp.delete();
    wr_exp.delete();
  endtask

  // Reset during stage 0 at cycle 7: outputs clear from cycle 8, restart at cycle 10.
  task automatic reset_mid();
    for (int rel = 0; rel < 10; rel++) begin
      bus.start = (rel == 0);
      reset     = (rel == 7);
      @(negedge clk);
      if (rel == 1) begin
        check("pre_rd_en", 32'(bus.rd_en), 32'(1));
        check("pre_tw", 32'(bus.tw_addr), 32'(4));
      end
      if (rel == 6) check("pre_wr_en", 32'(bus.wr_en), 32'(1));
      if (rel >= 8) check("zero_after_reset", out_vec(), 32'(0));
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    run_transform('0, '0);
  endtask

  initial begin
    logic [127:0] smask;
    logic [127:0] pmask;
    reset     = 1'b1;
    bus.start = 1'b0;
`ifdef NTT_SCHED_STALL_EN
    bus.stall = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", out_vec(), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    phase = "basic";
    run_transform('0, '0);

    phase = "start_ignored";
    pmask     = '0;
    pmask[3]  = 1'b1;
    pmask[12] = 1'b1;
    run_transform(pmask, '0);

    phase = "reset_mid";
    reset_mid();

`ifdef NTT_SCHED_STALL_EN
    phase = "stall_2_3";
    smask    = '0;
    smask[2] = 1'b1;
    smask[3] = 1'b1;
    run_transform('0, smask);

    phase = "stall_random";
    smask = '0;
    for (int c = 1; c < 60; c++) smask[c] = ($urandom_range(0, 3) == 0);
    run_transform('0, smask);
`else
    smask = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
